// File: rtl/fwd_hazard_ctrl_pkg.sv
// rtl/fwd_hazard_ctrl_pkg.sv - forwarding select codes and scoreboard entry layout
package fwd_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int SB_AW = 5;
    localparam logic [SB_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic             valid;
        logic             regwr;
        logic             memrd;
        logic [SB_AW-1:0] rd;
        logic [SB_AW-1:0] rs;
        logic [SB_AW-1:0] rt;
        logic             use_rs;
        logic             use_rt;
    } sb_entry_t;

endpackage

// File: rtl/fwd_hazard_ctrl_sel.sv
// rtl/fwd_hazard_ctrl_sel.sv - one operand's forwarding select from the MEM and WB entries
module fwd_sel_logic
    import fwd_hazard_ctrl_pkg::*;
(
    input  logic             src_valid,
    input  logic             use_src,
    input  logic [SB_AW-1:0] src,
    input  sb_entry_t        mem_entry,
    input  sb_entry_t        wb_entry,
    output logic [1:0]       sel
);

    logic mem_hit;
    logic wb_hit;
    logic unused_fields;

    assign mem_hit = src_valid & use_src & mem_entry.valid & mem_entry.regwr &
                     (mem_entry.rd != REG_ZERO) & (mem_entry.rd == src);
    assign wb_hit  = src_valid & use_src & wb_entry.valid & wb_entry.regwr &
                     (wb_entry.rd != REG_ZERO) & (wb_entry.rd == src);

    // The younger EX/MEM result always wins over MEM/WB.
    always_comb begin
        sel = FWD_REG;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

    assign unused_fields = ^{mem_entry.memrd, mem_entry.rs, mem_entry.rt, mem_entry.use_rs,
                             mem_entry.use_rt, wb_entry.memrd, wb_entry.rs, wb_entry.rt,
                             wb_entry.use_rs, wb_entry.use_rt};

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - EX/MEM/WB scoreboard driving operand forwarding and load-use stalls
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = SB_AW,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_use_rs_i,
    input  logic              id_use_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwr_i,
    input  logic              id_memrd_i,
    input  logic              flush_i,
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    sb_entry_t        ex_q;
    sb_entry_t        mem_q;
    sb_entry_t        wb_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             hz;

    fwd_sel_logic u_sel_a (
        .src_valid (ex_q.valid),
        .use_src   (ex_q.use_rs),
        .src       (ex_q.rs),
        .mem_entry (mem_q),
        .wb_entry  (wb_q),
        .sel       (fwd_a_sel_o)
    );

    fwd_sel_logic u_sel_b (
        .src_valid (ex_q.valid),
        .use_src   (ex_q.use_rt),
        .src       (ex_q.rt),
        .mem_entry (mem_q),
        .wb_entry  (wb_q),
        .sel       (fwd_b_sel_o)
    );

    // A load still in EX cannot forward yet; its consumer in ID must wait one cycle.
    assign hz = id_valid_i & ex_q.valid & ex_q.memrd & ex_q.regwr & (ex_q.rd != REG_ZERO) &
                ((id_use_rs_i & (ex_q.rd == id_rs_i)) | (id_use_rt_i & (ex_q.rd == id_rt_i)));

    assign stall_o     = hz & ~flush_i;
    assign stall_cnt_o = stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (id_valid_i && !flush_i && !stall_o) begin
                ex_q <= '{valid:  1'b1,
                          regwr:  id_regwr_i,
                          memrd:  id_memrd_i,
                          rd:     id_rd_i,
                          rs:     id_rs_i,
                          rt:     id_rt_i,
                          use_rs: id_use_rs_i,
                          use_rt: id_use_rt_i};
            end else begin
                ex_q <= '0;
            end
            if (stall_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - table-driven bench for fwd_hazard_ctrl
module tb_fwd_hazard_ctrl;

    localparam int CNT_W = 6;
    localparam int NVEC  = 30;

    typedef struct {
        logic       rst;
        logic       chk;
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       fl;
        logic [1:0] ea;
        logic [1:0] eb;
        logic       es;
        logic [CNT_W-1:0] ec;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [4:0]       id_rd;
    logic             id_regwr;
    logic             id_memrd;
    logic             flush;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t tbl [NVEC];

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .id_valid_i  (id_valid),
        .id_rs_i     (id_rs),
        .id_rt_i     (id_rt),
        .id_use_rs_i (id_use_rs),
        .id_use_rt_i (id_use_rt),
        .id_rd_i     (id_rd),
        .id_regwr_i  (id_regwr),
        .id_memrd_i  (id_memrd),
        .flush_i     (flush),
        .fwd_a_sel_o (fwd_a_sel),
        .fwd_b_sel_o (fwd_b_sel),
        .stall_o     (stall),
        .stall_cnt_o (stall_cnt)
    );

    function automatic vec_t mk(int r, int c, int v, int rs_, int rt_, int urs, int urt, int rd_,
                                int rw, int mr, int fl, int ea, int eb, int es, int ec);
        vec_t x;
        x.rst = r[0];  x.chk = c[0];  x.valid = v[0];
        x.rs = rs_[4:0]; x.rt = rt_[4:0]; x.urs = urs[0]; x.urt = urt[0];
        x.rd = rd_[4:0]; x.rw = rw[0]; x.mr = mr[0]; x.fl = fl[0];
        x.ea = ea[1:0]; x.eb = eb[1:0]; x.es = es[0]; x.ec = ec[CNT_W-1:0];
        return x;
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic r, logic v, int rs_, int rt_, logic urs, logic urt, int rd_,
                         logic rw, logic mr, logic fl);
        rst = r; id_valid = v; id_rs = rs_[4:0]; id_rt = rt_[4:0];
        id_use_rs = urs; id_use_rt = urt; id_rd = rd_[4:0];
        id_regwr = rw; id_memrd = mr; flush = fl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            rst chk v rs rt urs urt rd rw mr fl  ea eb es ec
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 1, 1, 2, 1, 1, 3, 1, 0, 0,  0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 1, 3, 5, 1, 1, 6, 1, 0, 0,  0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0);
        tbl[4]  = mk(0, 1, 1, 1, 2, 1, 1, 3, 1, 0, 0,  0, 0, 0, 0);
        tbl[5]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
        tbl[6]  = mk(0, 1, 1, 7, 3, 1, 1, 8, 1, 0, 0,  0, 0, 0, 0);
        tbl[7]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0);
        tbl[8]  = mk(0, 1, 1, 1, 2, 1, 1, 3, 1, 0, 0,  0, 0, 0, 0);
        tbl[9]  = mk(0, 1, 1, 1, 2, 1, 1, 3, 1, 0, 0,  0, 0, 0, 0);
        tbl[10] = mk(0, 1, 1, 9, 3, 1, 1, 10, 1, 0, 0, 0, 0, 0, 0);
        tbl[11] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 2, 0, 0);
        tbl[12] = mk(0, 1, 1, 1, 4, 1, 0, 4, 1, 1, 0,  0, 0, 0, 0);
        tbl[13] = mk(0, 1, 1, 4, 2, 1, 1, 5, 1, 0, 0,  0, 0, 1, 0);
        tbl[14] = mk(0, 1, 1, 4, 2, 1, 1, 5, 1, 0, 0,  0, 0, 0, 1);
        tbl[15] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1);
        tbl[16] = mk(0, 1, 1, 1, 4, 1, 0, 4, 1, 1, 0,  0, 0, 0, 1);
        tbl[17] = mk(0, 1, 1, 2, 4, 1, 0, 4, 1, 0, 0,  0, 0, 0, 1);
        tbl[18] = mk(0, 1, 1, 1, 2, 1, 1, 0, 1, 0, 0,  0, 0, 0, 1);
        tbl[19] = mk(0, 1, 1, 0, 0, 1, 1, 9, 1, 0, 0,  0, 0, 0, 1);
        tbl[20] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
        tbl[21] = mk(0, 1, 1, 1, 4, 1, 0, 4, 1, 1, 0,  0, 0, 0, 1);
        tbl[22] = mk(0, 1, 1, 4, 2, 1, 1, 5, 1, 0, 1,  0, 0, 0, 1);
        tbl[23] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
        tbl[24] = mk(0, 1, 1, 1, 2, 1, 1, 3, 1, 0, 0,  0, 0, 0, 1);
        tbl[25] = mk(0, 1, 1, 3, 3, 1, 1, 3, 1, 0, 0,  0, 0, 0, 1);
        tbl[26] = mk(0, 1, 1, 3, 3, 1, 1, 3, 1, 0, 0,  2, 2, 0, 1);
        tbl[27] = mk(1, 1, 1, 3, 3, 1, 1, 3, 1, 0, 0,  2, 2, 0, 1);
        tbl[28] = mk(0, 1, 1, 3, 3, 1, 1, 3, 1, 0, 0,  0, 0, 0, 0);
        tbl[29] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].rst, tbl[i].valid, int'(tbl[i].rs), int'(tbl[i].rt), tbl[i].urs,
                  tbl[i].urt, int'(tbl[i].rd), tbl[i].rw, tbl[i].mr, tbl[i].fl);
            #3;
            if (tbl[i].chk) begin
                check($sformatf("vec%0d fwd_a", i), 16'(fwd_a_sel), 16'(tbl[i].ea));
                check($sformatf("vec%0d fwd_b", i), 16'(fwd_b_sel), 16'(tbl[i].eb));
                check($sformatf("vec%0d stall", i), 16'(stall), 16'(tbl[i].es));
                check($sformatf("vec%0d cnt", i), 16'(stall_cnt), 16'(tbl[i].ec));
            end
            next_cycle();
        end

        // Back-to-back load-use pairs drive the counter past its ceiling.
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            drive(1'b0, 1'b1, 1, 4, 1'b1, 1'b0, 4, 1'b1, 1'b1, 1'b0);
            #3;
            check($sformatf("sat%0d no_stall", i), 16'(stall), 16'd0);
            next_cycle();
            drive(1'b0, 1'b1, 4, 2, 1'b1, 1'b1, 5, 1'b1, 1'b0, 1'b0);
            #3;
            check($sformatf("sat%0d stall", i), 16'(stall), 16'd1);
            check($sformatf("sat%0d cnt", i), 16'(stall_cnt),
                  16'((i < (1 << CNT_W) - 1) ? i : (1 << CNT_W) - 1));
            next_cycle();
        end
        drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        #3;
        check("sat_final cnt", 16'(stall_cnt), 16'((1 << CNT_W) - 1));
        check("sat_final stall", 16'(stall), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
